// File: rtl/reg_file_banked_pkg.sv
// Shared types and default constants for the banked register file.
package regfile_pkg;

   localparam int unsigned W_DEF       = 8;
   localparam int unsigned D_DEF       = 4;
   localparam int unsigned ZERO_IX_DEF = (2 ** D_DEF) - 1;
   localparam int unsigned PROT_IX_DEF = (2 ** D_DEF) - 2;

   typedef logic [W_DEF-1:0] word_t;
   typedef logic [D_DEF-1:0] regaddr_t;

   typedef enum logic {
      BANK_NORMAL = 1'b0,
      BANK_SHADOW = 1'b1
   } bank_e;

   // Other bank; used on a swap request.
   function automatic bank_e bank_toggle(input bank_e b);
      return (b == BANK_NORMAL) ? BANK_SHADOW : BANK_NORMAL;
   endfunction

endpackage

// File: rtl/reg_file_banked_if.sv
// Decode/ALU-side bus of the banked register file.
interface reg_file_banked_if #(
   parameter int unsigned W  = 8,
   parameter int unsigned D  = 4,
   parameter int unsigned NR = 2
);

   logic                       RegWrite;
   logic [D-1:0]               writeReg;
   logic [W-1:0]               writeValue;
   logic [NR-1:0][D-1:0]       srcAddr;
   logic [NR-1:0][W-1:0]       readData;
   logic                       sameSrc;
   logic                       BankSwap;
   logic                       ActiveBank;

   // Decode/ALU side drives addresses and write data.
   modport master (
      output RegWrite, writeReg, writeValue, srcAddr, BankSwap,
      input  readData, sameSrc, ActiveBank
   );

   // Register file side.
   modport slave (
      input  RegWrite, writeReg, writeValue, srcAddr, BankSwap,
      output readData, sameSrc, ActiveBank
   );

endinterface

// File: rtl/reg_file_banked_rf_read_port.sv
// One combinational read port: zero index, write bypass, then array select.
module rf_read_port #(
   parameter int unsigned W       = 8,
   parameter int unsigned D       = 4,
   parameter int unsigned ZERO_IX = (2 ** D) - 1,
   parameter bit          BYPASS  = 1'b1
) (
   input  logic                      in_reset_i,
   input  logic [D-1:0]              rd_addr_i,
   // Write enable already qualified against the zero/protected indices.
   input  logic                      wr_en_i,
   input  logic [D-1:0]              wr_addr_i,
   input  logic [W-1:0]              wr_data_i,
   input  logic [(2**D)-1:0][W-1:0]  bank_i,
   output logic [W-1:0]              rd_data_o
);

   localparam logic [D-1:0] ZeroAddr = D'(ZERO_IX);

   logic hit_bypass;

   assign hit_bypass = BYPASS && wr_en_i && (wr_addr_i == rd_addr_i);

   // Priority: reset, hardwired zero, in-flight write, stored value.
   always_comb begin
      rd_data_o = '0;
      if (in_reset_i) begin
         rd_data_o = '0;
      end else if (rd_addr_i == ZeroAddr) begin
         rd_data_o = '0;
      end else if (hit_bypass) begin
         rd_data_o = wr_data_i;
      end else begin
         rd_data_o = bank_i[rd_addr_i];
      end
   end

endmodule

// File: rtl/reg_file_banked.sv
// Two-bank register file with NR read ports, one write port and bank swap.
module reg_file_banked
   import regfile_pkg::*;
#(
   parameter int unsigned W       = W_DEF,
   parameter int unsigned D       = D_DEF,
   parameter int unsigned NR      = 2,
   parameter int unsigned ZERO_IX = (2 ** D) - 1,
   parameter int unsigned PROT_IX = (2 ** D) - 2,
   parameter bit          BYPASS  = 1'b1
) (
   input  logic               CLK,
   input  logic               Reset_n,
   reg_file_banked_if.slave   bus
);

   localparam int unsigned  NREG     = 2 ** D;
   localparam logic [D-1:0] ZeroAddr = D'(ZERO_IX);
   localparam logic [D-1:0] ProtAddr = D'(PROT_IX);

   logic [1:0][NREG-1:0][W-1:0] core_q, core_d;
   bank_e                       bank_q, bank_d;
   logic                        bank_idx;
   logic                        wr_en;
   logic [NREG-1:0][W-1:0]      active_words;
   logic [NR-1:0][W-1:0]        rd_data;

   assign bank_idx     = (bank_q == BANK_SHADOW);
   assign active_words = core_q[bank_idx];

   // Writes to the zero and protected indices are dropped here, so bypass never forwards them.
   assign wr_en = bus.RegWrite && (bus.writeReg != ProtAddr) && (bus.writeReg != ZeroAddr);

   // Next-state: the write targets the pre-edge bank even when a swap happens on the same edge.
   always_comb begin
      core_d = core_q;
      bank_d = bank_q;
      if (wr_en) begin
         core_d[bank_idx][bus.writeReg] = bus.writeValue;
      end
      if (bus.BankSwap) begin
         bank_d = bank_toggle(bank_q);
      end
   end

   // State registers; async reset clears both banks and selects the normal bank.
   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         core_q <= '0;
         bank_q <= BANK_NORMAL;
      end else begin
         core_q <= core_d;
         bank_q <= bank_d;
      end
   end

   for (genvar i = 0; i < NR; i++) begin : g_rd
      rf_read_port #(
         .W       (W),
         .D       (D),
         .ZERO_IX (ZERO_IX),
         .BYPASS  (BYPASS)
      ) u_rd (
         .in_reset_i (!Reset_n),
         .rd_addr_i  (bus.srcAddr[i]),
         .wr_en_i    (wr_en),
         .wr_addr_i  (bus.writeReg),
         .wr_data_i  (bus.writeValue),
         .bank_i     (active_words),
         .rd_data_o  (rd_data[i])
      );
   end

   assign bus.readData   = rd_data;
   assign bus.ActiveBank = bank_idx;
   // Feeds the shifter-mode select; ignores bank and zero index on purpose.
   assign bus.sameSrc    = (bus.srcAddr[0] == bus.srcAddr[1]);

endmodule

// File: tb/tb_reg_file_banked.sv
// Scoreboard bench: two DUTs (bypass on/off) share stimulus; a monitor checks queued expectations.
module tb_reg_file_banked;
   import regfile_pkg::*;

   localparam int unsigned NR = 4;
   localparam int unsigned ZX = 15;
   localparam int unsigned PX = 14;

   logic CLK = 1'b0;
   logic Reset_n = 1'b0;

   reg_file_banked_if #(.W(8), .D(4), .NR(NR)) if_b ();
   reg_file_banked_if #(.W(8), .D(4), .NR(NR)) if_n ();

   reg_file_banked #(.W(8), .D(4), .NR(NR), .ZERO_IX(ZX), .PROT_IX(PX), .BYPASS(1'b1)) u_dut_b (
      .CLK     (CLK),
      .Reset_n (Reset_n),
      .bus     (if_b)
   );

   reg_file_banked #(.W(8), .D(4), .NR(NR), .ZERO_IX(ZX), .PROT_IX(PX), .BYPASS(1'b0)) u_dut_n (
      .CLK     (CLK),
      .Reset_n (Reset_n),
      .bus     (if_n)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [NR-1:0][7:0] rd_b;
      logic [NR-1:0][7:0] rd_n;
      logic               same;
      logic               bank;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;
   bit   drv_done = 1'b0;

   // Reference model: plain arrays indexed by bank and register.
   logic [7:0] mem [2][16];
   int         mbank;

   function automatic logic [7:0] model_read(input int a, input bit byp, input bit rst,
                                             input bit we, input int wa, input logic [7:0] wv);
      if (rst || a == ZX) return 8'h00;
      if (byp && we && wa == a && wa != PX && wa != ZX) return wv;
      return mem[mbank][a];
   endfunction

   task automatic chk(input string name, input int port, input logic [7:0] act,
                      input logic [7:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s[%0d] @%0t: got %02h, required %02h", name, port, $time, act, req);
      end
   endtask

   // One cycle: drive at negedge, queue expectations, apply model update after the posedge.
   task automatic cyc(input bit rst, input bit we, input int wa, input logic [7:0] wv,
                      input bit swap, input logic [NR-1:0][3:0] sa);
      exp_t e;
      @(negedge CLK);
      Reset_n = !rst;
      if (rst) begin
         for (int b = 0; b < 2; b++)
            for (int r = 0; r < 16; r++) mem[b][r] = 8'h00;
         mbank = 0;
      end
      if_b.RegWrite = we;  if_n.RegWrite = we;
      if_b.writeReg = 4'(wa); if_n.writeReg = 4'(wa);
      if_b.writeValue = wv; if_n.writeValue = wv;
      if_b.BankSwap = swap; if_n.BankSwap = swap;
      if_b.srcAddr = sa;    if_n.srcAddr = sa;
      for (int i = 0; i < NR; i++) begin
         e.rd_b[i] = model_read(int'(sa[i]), 1'b1, rst, we, wa, wv);
         e.rd_n[i] = model_read(int'(sa[i]), 1'b0, rst, we, wa, wv);
      end
      e.same = (sa[0] == sa[1]);
      e.bank = mbank[0];
      exp_q.push_back(e);
      @(posedge CLK);
      #1;
      if (!rst) begin
         if (we && wa != PX && wa != ZX) mem[mbank][wa] = wv;
         if (swap) mbank = 1 - mbank;
      end
   endtask

   function automatic logic [NR-1:0][3:0] addrs(input int a0, input int a1, input int a2,
                                                input int a3);
      logic [NR-1:0][3:0] s;
      s[0] = 4'(a0); s[1] = 4'(a1); s[2] = 4'(a2); s[3] = 4'(a3);
      return s;
   endfunction

   // Monitor: combinational outputs settle right after the negedge drive.
   initial begin
      exp_t e;
      forever begin
         @(negedge CLK);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            for (int i = 0; i < NR; i++) begin
               chk("rd_bypass", i, if_b.readData[i], e.rd_b[i]);
               chk("rd_nobypass", i, if_n.readData[i], e.rd_n[i]);
            end
            chk("sameSrc_b", 0, {7'd0, if_b.sameSrc}, {7'd0, e.same});
            chk("sameSrc_n", 0, {7'd0, if_n.sameSrc}, {7'd0, e.same});
            chk("bank_b", 0, {7'd0, if_b.ActiveBank}, {7'd0, e.bank});
            chk("bank_n", 0, {7'd0, if_n.ActiveBank}, {7'd0, e.bank});
         end
      end
   end

   // Stimulus: directed scenarios then randomized traffic with occasional resets.
   initial begin
      logic [NR-1:0][3:0] sa;
      int wa;
      if_b.RegWrite = 0; if_n.RegWrite = 0;
      if_b.writeReg = '0; if_n.writeReg = '0;
      if_b.writeValue = '0; if_n.writeValue = '0;
      if_b.BankSwap = 0; if_n.BankSwap = 0;
      if_b.srcAddr = '0; if_n.srcAddr = '0;
      mbank = 0;
      for (int b = 0; b < 2; b++)
         for (int r = 0; r < 16; r++) mem[b][r] = 8'h00;

      cyc(1, 0, 0, 8'h00, 0, addrs(0, 1, 2, 3));
      cyc(1, 1, 3, 8'h99, 1, addrs(3, 3, 15, 14));
      // Reset mid-cycle with a pending write
      cyc(0, 1, 3, 8'h5A, 0, addrs(3, 0, 1, 2));
      cyc(0, 0, 0, 8'h00, 0, addrs(3, 3, 4, 5));
      cyc(1, 1, 3, 8'hAA, 1, addrs(3, 4, 5, 6));
      cyc(0, 0, 0, 8'h00, 0, addrs(3, 3, 4, 5));
      // Write/read with and without bypass
      cyc(0, 1, 4, 8'hC3, 0, addrs(4, 3, 4, 0));
      cyc(0, 0, 0, 8'h00, 0, addrs(4, 3, 2, 1));
      // Zero and protected indices
      cyc(0, 1, 15, 8'hFF, 0, addrs(15, 14, 4, 3));
      cyc(0, 1, 14, 8'hFF, 0, addrs(14, 15, 4, 3));
      cyc(0, 0, 0, 8'h00, 0, addrs(15, 14, 4, 3));
      // Banks
      cyc(0, 1, 2, 8'h11, 0, addrs(2, 4, 0, 1));
      cyc(0, 0, 0, 8'h00, 1, addrs(2, 4, 0, 1));
      cyc(0, 1, 2, 8'h22, 0, addrs(2, 4, 0, 1));
      cyc(0, 0, 0, 8'h00, 1, addrs(2, 4, 0, 1));
      cyc(0, 0, 0, 8'h00, 0, addrs(2, 4, 0, 1));
      cyc(0, 0, 0, 8'h00, 1, addrs(2, 4, 0, 1));
      cyc(0, 0, 0, 8'h00, 0, addrs(2, 4, 0, 1));
      cyc(0, 0, 0, 8'h00, 1, addrs(2, 5, 0, 1));
      // Swap and write on the same edge: write lands in the old bank
      cyc(0, 1, 5, 8'h77, 1, addrs(5, 2, 0, 1));
      cyc(0, 0, 0, 8'h00, 0, addrs(5, 2, 0, 1));
      cyc(0, 0, 0, 8'h00, 1, addrs(5, 2, 0, 1));
      cyc(0, 0, 0, 8'h00, 0, addrs(5, 2, 0, 1));
      // sameSrc and independent ports
      cyc(0, 0, 0, 8'h00, 0, addrs(7, 7, 2, 5));
      cyc(0, 0, 0, 8'h00, 0, addrs(7, 8, 5, 2));

      for (int n = 0; n < 400; n++) begin
         wa = int'($urandom_range(0, 15));
         for (int i = 0; i < NR; i++)
            sa[i] = ($urandom_range(0, 2) == 0) ? 4'(wa) : 4'($urandom_range(0, 15));
         cyc(($urandom_range(0, 49) == 0), $urandom_range(0, 1) == 1, wa,
             8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0), sa);
      end

      drv_done = 1'b1;
      repeat (3) @(posedge CLK);
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: driver_done=%0d, required 1", drv_done);
      $fatal(1, "time limit");
   end

endmodule
